// File: rtl/eightbit_mem.sv
// ---------------------------------------------------------------------------
// eightbit_mem
//   Memory-side responder for the eightbit CPU bus. Holds a 2^ADDR_W x DATA_W
//   RAM with a one-cycle registered read and a synchronous write.
//
//   Boot sequence:
//     CLEAR - writes INIT_FILL to every location, one per cycle.
//     LOAD  - accepts a byte stream from the loader port, starting at LOAD_BASE.
//     RUN   - releases the CPU and serves its bus. Stores to IO_ADDR are also
//             mirrored to io_out with a one-cycle io_strobe.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (restarts at CLEAR)
//   addr       CPU address
//   data_in    CPU write data
//   we         CPU write enable (only honoured in RUN)
//   data_out   registered read data (0 outside RUN)
//   ld_data    loader byte
//   ld_valid   loader byte valid
//   ld_last    marks the final loader byte
//   ld_ready   loader may transfer (registered, high throughout LOAD)
//   cpu_rst    reset to the CPU core (registered, low only in RUN)
//   io_out     last value stored to IO_ADDR
//   io_strobe  one-cycle pulse per store to IO_ADDR
// ---------------------------------------------------------------------------
module eightbit_mem #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] IO_ADDR   = 8'hE0,
  parameter logic [DATA_W-1:0] INIT_FILL = 8'h00,
  parameter logic [ADDR_W-1:0] LOAD_BASE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic [DATA_W-1:0] io_out,
  output logic              io_strobe
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0]   ld_ptr_q, ld_ptr_d;
  logic                ld_ready_q, ld_ready_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic [DATA_W-1:0]   data_out_q;
  logic [DATA_W-1:0]   io_out_q, io_out_d;
  logic                io_strobe_q, io_strobe_d;

  // Single write port shared by the clear sequencer, the loader and the CPU.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                ld_xfer;

  logic [DATA_W-1:0]   mem [DEPTH];

  // ld_ready_q is only ever high in LOAD, but qualify with the state anyway
  // so a stray handshake can never write outside LOAD.
  assign ld_xfer = (state_q == ST_LOAD) && ld_valid && ld_ready_q;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    ld_ptr_d    = ld_ptr_q;
    io_out_d    = io_out_q;
    io_strobe_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_ptr_q;
    mem_wdata   = INIT_FILL;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        // The pointer wrapping back to zero is the end of CLEAR.
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_xfer) begin
          mem_we    = 1'b1;
          mem_waddr = ld_ptr_q;
          mem_wdata = ld_data;
          ld_ptr_d  = ld_ptr_q + 1'b1;
          // A full RAM ends loading rather than wrapping over address 0.
          if (ld_last || (ld_ptr_q == LAST_ADDR)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (we) begin
          mem_we    = 1'b1;
          mem_waddr = addr;
          mem_wdata = data_in;
          if (addr == IO_ADDR) begin
            io_out_d    = data_in;
            io_strobe_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // Registered handshake/reset outputs follow the state being entered, so
    // they change on the same edge as the state itself.
    ld_ready_d = (state_d == ST_LOAD);
    cpu_rst_d  = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      ld_ptr_q    <= LOAD_BASE;
      ld_ready_q  <= 1'b0;
      cpu_rst_q   <= 1'b1;
      data_out_q  <= '0;
      io_out_q    <= '0;
      io_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ld_ptr_q    <= ld_ptr_d;
      ld_ready_q  <= ld_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
      // Read samples the array before this edge's write lands, giving
      // read-before-write on a same-address access.
      if (state_q == ST_RUN) begin
        data_out_q <= mem[addr];
      end else begin
        data_out_q <= '0;
      end
    end
  end

  // RAM contents are deliberately not reset; CLEAR initialises them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out  = data_out_q;
  assign ld_ready  = ld_ready_q;
  assign cpu_rst   = cpu_rst_q;
  assign io_out    = io_out_q;
  assign io_strobe = io_strobe_q;

endmodule

// File: tb/tb_eightbit_mem.sv
// ---------------------------------------------------------------------------
// tb_eightbit_mem
//   Directed bench for eightbit_mem: boot clear, program load, CPU reads and
//   writes, IO mirroring, reset abort mid-load and a full-RAM stream load.
//   Inputs are driven on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_eightbit_mem;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       we;
  logic [7:0] data_out;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_last;
  logic       ld_ready;
  logic       cpu_rst;
  logic [7:0] io_out;
  logic       io_strobe;

  int n_total;
  int n_pass;

  logic [7:0] exp_mem [256];
  logic [7:0] prog [18];

  eightbit_mem dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .we        (we),
    .data_out  (data_out),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_rst   (cpu_rst),
    .io_out    (io_out),
    .io_strobe (io_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts edges from reset release until ld_ready rises (bounded).
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ld_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    $display("clear %s: ld_ready after %0d cycles", tag, n);
    check(tag, n, 256);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input string tag);
    addr = a;
    we   = 1'b0;
    tick();
    $display("rd addr=0x%02h data=0x%02h", a, data_out);
    check(tag, data_out, exp_mem[a]);
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    addr     = 8'h40;
    data_in  = 8'hAA;
    we       = 1'b1;      // must be ignored outside RUN
    ld_data  = 8'h00;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    prog = '{8'h50, 8'h01, 8'h51, 8'h00, 8'h5F, 8'hE0, 8'h5E, 8'h08, 8'h20,
             8'hF0, 8'h42, 8'h00, 8'h30, 8'h10, 8'h41, 8'h20, 8'h0E, 8'h00};
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;

    // ---- reset values ----
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_data_out", data_out, 0);
    check("rst_io_out", io_out, 0);
    check("rst_io_strobe", io_strobe, 0);
    rst = 1'b0;

    // ---- CLEAR then load 18-byte program ----
    wait_ready("clear_len_1");
    check("load_cpu_rst", cpu_rst, 1);
    for (int i = 0; i < 18; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = (i == 17);
      if (i == 5) begin
        addr = 8'h02;
        check("load_data_out_zero", data_out, 0);
        addr = 8'h40;
      end
      if (i == 17) check("pre_last_ready", ld_ready, 1);
      tick();
      exp_mem[i] = prog[i];
      $display("ld addr=0x%02h data=0x%02h last=%0d", i, prog[i], i == 17);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("post_load_ready", ld_ready, 0);
    check("post_load_cpu_rst", cpu_rst, 0);
    we = 1'b0;

    // ---- full readback: program, zeros, 0x40 untouched by load-phase we ----
    for (int i = 0; i < 256; i++) rd(8'(i), $sformatf("readback_%02h", i));

    // ---- directed reads ----
    rd(8'h02, "read_02");
    check("read_02_val", data_out, 8'h51);
    rd(8'h05, "read_05");
    check("read_05_val", data_out, 8'hE0);

    // ---- IO store ----
    addr = 8'hE0; data_in = 8'h05; we = 1'b1;
    tick();
    $display("wr addr=0xe0 data=0x05");
    check("io_strobe_1", io_strobe, 1);
    check("io_out_1", io_out, 8'h05);
    check("io_rbw_old", data_out, 8'h00);
    we = 1'b0;
    tick();
    check("io_strobe_drop", io_strobe, 0);
    check("io_read_new", data_out, 8'h05);

    // back-to-back IO stores
    we = 1'b1; data_in = 8'h07;
    tick();
    $display("wr addr=0xe0 data=0x07");
    check("b2b_strobe_a", io_strobe, 1);
    check("b2b_io_a", io_out, 8'h07);
    data_in = 8'h09;
    tick();
    $display("wr addr=0xe0 data=0x09");
    check("b2b_strobe_b", io_strobe, 1);
    check("b2b_io_b", io_out, 8'h09);
    check("b2b_rbw", data_out, 8'h07);
    exp_mem[8'hE0] = 8'h09;

    // non-IO store: no strobe, io_out holds
    addr = 8'h30; data_in = 8'h3C;
    tick();
    we = 1'b0;
    $display("wr addr=0x30 data=0x3c");
    check("nonio_strobe", io_strobe, 0);
    check("nonio_io_hold", io_out, 8'h09);
    check("nonio_rbw", data_out, 8'h00);
    exp_mem[8'h30] = 8'h3C;
    rd(8'h30, "read_30");
    rd(8'hE0, "read_e0");

    // ---- reset mid-load ----
    do_reset();
    check("rerun_io_out_rst", io_out, 0);
    ld_valid = 1'b1; ld_data = 8'h77;   // ignored during CLEAR
    wait_ready("clear_len_2");
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h11 + 8'(i);
      tick();
      $display("ld addr=0x%02h data=0x%02h last=0", i, ld_data);
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_ld_ready", ld_ready, 0);
    check("abort_cpu_rst", cpu_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h77;
    wait_ready("clear_len_3");
    ld_data = 8'h99; ld_last = 1'b1;
    tick();
    $display("ld addr=0x00 data=0x99 last=1");
    ld_valid = 1'b0; ld_last = 1'b0;
    check("abort_run_cpu_rst", cpu_rst, 0);
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    exp_mem[0] = 8'h99;
    rd(8'h00, "abort_read_00");
    rd(8'h01, "abort_read_01");
    rd(8'h04, "abort_read_04");
    rd(8'hE0, "abort_read_e0");

    // ---- 256-byte stream with no ld_last ----
    do_reset();
    wait_ready("clear_len_4");
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i) ^ 8'h5A;
      if (i == 255) check("full_pre_ready", ld_ready, 1);
      tick();
      exp_mem[i] = 8'(i) ^ 8'h5A;
      $display("ld addr=0x%02h data=0x%02h last=0", i, 8'(i) ^ 8'h5A);
    end
    ld_data = 8'hEE;   // would land on 0x00 if the pointer wrapped
    check("full_ready_drop", ld_ready, 0);
    check("full_cpu_rst", cpu_rst, 0);
    tick();
    ld_valid = 1'b0;
    rd(8'h00, "full_read_00");
    rd(8'h80, "full_read_80");
    rd(8'hFF, "full_read_ff");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
